// File: rtl/serial_adder_pkg.sv
// Shared encodings and defaults for the bit-serial adder controller.
// Consumed by serial_adder_ctrl; no configuration macros live here.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_slice.sv
// One-bit full adder slice (fa_slice) assembled from two half_adder cells and an OR.
// Shared by the serial controller for every bit position of the operands.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

module fa_slice (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic cout
);

    logic w_partialSum;
    logic w_generate;
    logic w_propagateCarry;

    half_adder u_haInputs (
        .i_a (x),
        .i_b (y),
        .o_s (w_partialSum),
        .o_c (w_generate)
    );

    half_adder u_haCarry (
        .i_a (w_partialSum),
        .i_b (ci),
        .o_s (s),
        .o_c (w_propagateCarry)
    );

    assign cout = w_generate | w_propagateCarry;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one fa_slice reused LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t r_state;
    state_t w_nextState;
    logic   w_accept;
    logic   w_lastBit;

    logic [WIDTH-1:0] r_aShift;
    logic [WIDTH-1:0] r_bShift;
    // Holds the WIDTH-1 sum bits already produced; the final bit joins them on the last cycle.
    logic [WIDTH-2:0] r_sumShift;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_sliceSum;
    logic             w_sliceCarry;
    logic [WIDTH-1:0] w_sumNext;

    fa_slice u_slice (
        .x    (r_aShift[0]),
        .y    (r_bShift[0]),
        .ci   (r_carry),
        .s    (w_sliceSum),
        .cout (w_sliceCarry)
    );

    assign w_lastBit = (r_count == CNT_W'(WIDTH - 1));
    assign w_sumNext = {w_sliceSum, r_sumShift};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start in the result cycle chains straight into the next addition.
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aShift   <= '0;
            r_bShift   <= '0;
            r_sumShift <= '0;
            r_carry    <= 1'b0;
            r_count    <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
        end else if (w_accept) begin
            r_aShift   <= a;
            r_bShift   <= b;
            r_sumShift <= '0;
            r_carry    <= cin;
            r_count    <= '0;
        end else if (r_state == RUN) begin
            r_aShift   <= r_aShift >> 1;
            r_bShift   <= r_bShift >> 1;
            r_sumShift <= w_sumNext[WIDTH-1:1];
            r_carry    <= w_sliceCarry;
            r_count    <= r_count + CNT_W'(1);
            if (w_lastBit) begin
                r_sum  <= w_sumNext;
                r_cout <= w_sliceCarry;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // r_carry is the carry into the MSB during the final RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_lastBit) begin
            r_ovf <= r_carry ^ w_sliceCarry;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8), directed plus randomized operations.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Reference: unsigned add gives {cout,sum}; signed range test gives overflow.
    function automatic logic [WIDTH:0] refAdd(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input logic opCin);
        int unsigned total;
        total = int'(opA) + int'(opB) + int'(opCin);
        return total[WIDTH:0];
    endfunction

    function automatic logic refOvf(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input logic opCin);
        int total;
        total = int'($signed(opA)) + int'($signed(opB)) + int'(opCin);
        return (total > (2 ** (WIDTH - 1)) - 1) || (total < -(2 ** (WIDTH - 1)));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one start pulse, then scrambles the operand inputs.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input logic opCin);
        @(negedge clk);
        start = 1'b1;
        a     = opA;
        b     = opB;
        cin   = opCin;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    // Waits (bounded) for done; optionally pulses start with junk operands mid-run.
    task automatic waitDone(input int interfereAt, output int busyCycles, output bit seen);
        busyCycles = 0;
        seen       = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            start = (i == interfereAt);
            if (i == interfereAt) begin
                a   = WIDTH'($urandom);
                b   = WIDTH'($urandom);
                cin = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic checkResult(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input logic opCin,
                               input int busyCycles, input bit seen);
        logic [WIDTH:0] expected;
        expected = refAdd(opA, opB, opCin);
        checkOutput("doneSeen", 64'(seen), 64'd1);
        checkOutput("busyCycles", 64'(busyCycles), 64'(WIDTH));
        checkOutput("busyInDone", 64'(busy), 64'd0);
        checkOutput("sum", 64'(sum), 64'(expected[WIDTH-1:0]));
        checkOutput("cout", 64'(cout), 64'(expected[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf", 64'(ovf), 64'(refOvf(opA, opB, opCin)));
`endif
    endtask

    task automatic runOp(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB, input logic opCin, input int interfereAt);
        int             busyCycles;
        bit             seen;
        logic [WIDTH:0] expected;
        expected = refAdd(opA, opB, opCin);
        applyStimulus(opA, opB, opCin);
        waitDone(interfereAt, busyCycles, seen);
        checkResult(opA, opB, opCin, busyCycles, seen);
        @(negedge clk);
        checkOutput("donePulseWidth", 64'(done), 64'd0);
        checkOutput("sumHeld", 64'(sum), 64'(expected[WIDTH-1:0]));
        checkOutput("coutHeld", 64'(cout), 64'(expected[WIDTH]));
    endtask

    initial begin
        int  busyCycles;
        bit  seen;
        bit  doneAfterReset;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetDone", 64'(done), 64'd0);
        checkOutput("resetSum", 64'(sum), 64'd0);
        checkOutput("resetCout", 64'(cout), 64'd0);
        rst = 1'b0;

        runOp(8'h0F, 8'h01, 1'b0, -1);
        runOp(8'hFF, 8'h01, 1'b0, -1);
        runOp(8'hFF, 8'hFF, 1'b1, -1);
        runOp(8'h7F, 8'h01, 1'b0, -1);
        runOp(8'h80, 8'h80, 1'b0, -1);

        // Back-to-back: start held in the DONE cycle launches the next addition.
        applyStimulus(8'h11, 8'h22, 1'b0);
        waitDone(-1, busyCycles, seen);
        checkResult(8'h11, 8'h22, 1'b0, busyCycles, seen);
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h80;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        checkOutput("b2bDoneDropped", 64'(done), 64'd0);
        checkOutput("b2bBusy", 64'(busy), 64'd1);
        waitDone(-1, busyCycles, seen);
        checkResult(8'h80, 8'h80, 1'b0, busyCycles, seen);
        @(negedge clk);
        checkOutput("b2bDonePulseWidth", 64'(done), 64'd0);

        // Start pulse with different operands while busy must be ignored.
        runOp(8'h12, 8'h34, 1'b0, 3);

        // Reset mid-operation aborts it and clears held results.
        applyStimulus(8'h0F, 8'h01, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortDone", 64'(done), 64'd0);
        checkOutput("abortSum", 64'(sum), 64'd0);
        checkOutput("abortCout", 64'(cout), 64'd0);
        doneAfterReset = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            doneAfterReset = doneAfterReset | done;
            @(negedge clk);
        end
        checkOutput("abortNoDone", 64'(doneAfterReset), 64'd0);
        runOp(8'h0F, 8'h01, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            runOp(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, WIDTH - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that time-shares one full-adder bit slice over an N-bit addition.
- The slice is built from two half_adder instances plus an OR.
- Handles operand capture, LSB-first shifting, carry storage, bit counting and a start/busy/done handshake.
- Sits between a requesting master and the shared adder slice; trades latency (WIDTH cycles) for area.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32)
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
- clk  input  1  single system clock, all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only when not busy
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  result, held stable from done until the next accepted start
- cout  output  1  final carry-out, held with sum

Behaviour:
- Reset: clk and rst as above; rst is synchronous, active-high.
  - While rst is high at a clk edge: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry reg=0, shift regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture a, b into shift regs; carry reg=cin; counter=0; clear sum shift reg; next=RUN.
  - start=0 → stay in IDLE.
- RUN (busy=1):
  - Each cycle the slice computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry).
  - sum_sr shifts right with s inserted at MSB; a_sr and b_sr shift right; carry reg ← c; counter increments.
  - When counter==WIDTH-1 at the edge → next=DONE; cout ← c.
- DONE:
  - done=1 for exactly one cycle, busy=0; sum output = sum_sr.
  - start=1 in DONE → accepted exactly as in IDLE (back-to-back operation, next=RUN).
  - Otherwise next=IDLE.
- Latency: start sampled at edge 0; RUN occupies edges 1..WIDTH; done is high in the cycle after edge WIDTH. Throughput is one result per WIDTH+1 cycles back-to-back.
- start while busy: ignored; inputs are not re-sampled and the operation is unaffected.
- a, b, cin changing during RUN: no effect (captured copies are used).
- sum/cout: registered, updated only on the DONE transition, and stable in IDLE.
- rst mid-operation: the operation is aborted; done is never asserted for it; all outputs return to 0.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside cout.
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
  - The carry into the MSB is the carry reg value during the final RUN cycle.
  - ovf resets to 0 and is held like sum.
- Undefined: no ovf port, no extra logic; behaviour otherwise identical.

Decomposition:
- Shared package/include (serial_adder_pkg):
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH constant
- One natural sub-module: fa_slice (output s, cout; input x, y, ci).
  - Built from two half_adder instances plus an OR gate.
  - Instantiated once inside serial_adder_ctrl.

Test Plan (WIDTH=8):
- a=0x0F, b=0x01, cin=0, start pulse → busy high for 8 cycles, done pulse at cycle 9, sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start 0x12+0x34; pulse start with a=0xAA, b=0x55 at cycle 4 → ignored, result sum=0x46, cout=0, single done pulse.
- Back-to-back: start held high in the DONE cycle with 0x80+0x80 → second RUN begins immediately, sum=0x00, cout=1, done 9 cycles later.
- Assert rst at cycle 5 of 0x0F+0x01 → next cycle busy=0, done never pulses, sum=0x00, cout=0; new start afterwards completes normally.
- SERIAL_ADDER_OVF_EN defined:
  - 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
  - 0xFF+0x01 → ovf=0.
